// File: rtl/half_adder_pkg.sv
// Common arithmetic helpers shared by the half adder, full adders and
// compressor trees built on top of it.
package half_adder_pkg;

    // Widest lane count any adder in this family is expected to use.
    localparam int MAX_WIDTH = 64;

    // Bits needed to hold a population count of 0..width without wrapping.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/half_adder_bit.sv
// Single-lane half adder cell: sum = a ^ b, cout = a & b.
module half_adder_bit (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule

// File: rtl/half_adder.sv
// Bank of independent half adders with a carry population count and an
// optional single output register stage qualified by out_valid.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int REGISTERED = 0,
    parameter int CNT_W      = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] cout,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_count
);

    logic [WIDTH-1:0] lane_sum;
    logic [WIDTH-1:0] lane_cout;
    logic [CNT_W-1:0] lane_count;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .sum  (lane_sum[i]),
            .cout (lane_cout[i])
        );
    end

    // Population count of the lane carries; CNT_W is sized so it never wraps.
    always_comb begin
        lane_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lane_count = lane_count + CNT_W'(lane_cout[i]);
        end
    end

    if (REGISTERED != 0) begin : g_reg
        // Output stage: reset flushes, valid samples load, idle cycles hold data.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_valid   <= 1'b0;
                sum         <= '0;
                cout        <= '0;
                carry_count <= '0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    sum         <= lane_sum;
                    cout        <= lane_cout;
                    carry_count <= lane_count;
                end
            end
        end
    end else begin : g_comb
        // Clock and reset play no part in the combinational configuration.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        // Zero-latency path straight from the lane cells.
        always_comb begin
            out_valid   = in_valid;
            sum         = lane_sum;
            cout        = lane_cout;
            carry_count = lane_count;
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// Checks combinational and registered half adder banks of width 1, 4 and 8
// against a behavioural model driven by directed and random stimulus.
module tb_half_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [0:0] a1, b1;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;

    logic [0:0] s1c, c1c, s1r, c1r;
    logic [3:0] s4c, c4c, s4r, c4r;
    logic [7:0] s8c, c8c, s8r, c8r;
    logic [0:0] n1c, n1r;
    logic [2:0] n4c, n4r;
    logic [3:0] n8c, n8r;
    logic       v1c, v1r, v4c, v4r, v8c, v8r;

    int checks   = 0;
    int failures = 0;

    int         wd[3] = '{1, 4, 8};
    logic [7:0] m_sum[3];
    logic [7:0] m_cout[3];
    int         m_cnt[3];
    logic       m_valid;

    always #5 clk = ~clk;

    half_adder #(.WIDTH(1), .REGISTERED(0)) u_w1c (.clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a1), .b(b1), .sum(s1c), .cout(c1c), .out_valid(v1c), .carry_count(n1c));
    half_adder #(.WIDTH(1), .REGISTERED(1)) u_w1r (.clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a1), .b(b1), .sum(s1r), .cout(c1r), .out_valid(v1r), .carry_count(n1r));
    half_adder #(.WIDTH(4), .REGISTERED(0)) u_w4c (.clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a4), .b(b4), .sum(s4c), .cout(c4c), .out_valid(v4c), .carry_count(n4c));
    half_adder #(.WIDTH(4), .REGISTERED(1)) u_w4r (.clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a4), .b(b4), .sum(s4r), .cout(c4r), .out_valid(v4r), .carry_count(n4r));
    half_adder #(.WIDTH(8), .REGISTERED(0)) u_w8c (.clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a8), .b(b8), .sum(s8c), .cout(c8c), .out_valid(v8c), .carry_count(n8c));
    half_adder #(.WIDTH(8), .REGISTERED(1)) u_w8r (.clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a8), .b(b8), .sum(s8r), .cout(c8r), .out_valid(v8r), .carry_count(n8r));

    function automatic logic [7:0] lane_mask(input int w);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < w; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int popc(input logic [7:0] x);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(x[i]);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational banks, clock the
    // model alongside the DUTs, then check the registered banks.
    task automatic cycle(input logic v, input logic r, input logic [7:0] av, input logic [7:0] bv);
        logic [7:0] es[3];
        logic [7:0] ec[3];
        rst      = r;
        in_valid = v;
        a1 = av[0];   b1 = bv[0];
        a4 = av[3:0]; b4 = bv[3:0];
        a8 = av;      b8 = bv;
        for (int k = 0; k < 3; k++) begin
            es[k] = (av ^ bv) & lane_mask(wd[k]);
            ec[k] = (av & bv) & lane_mask(wd[k]);
        end
        #1;
        chk("w1c_sum", 64'(s1c), 64'(es[0]));
        chk("w1c_cout", 64'(c1c), 64'(ec[0]));
        chk("w1c_cnt", 64'(n1c), 64'(popc(ec[0])));
        chk("w1c_valid", 64'(v1c), 64'(v));
        chk("w4c_sum", 64'(s4c), 64'(es[1]));
        chk("w4c_cout", 64'(c4c), 64'(ec[1]));
        chk("w4c_cnt", 64'(n4c), 64'(popc(ec[1])));
        chk("w4c_valid", 64'(v4c), 64'(v));
        chk("w8c_sum", 64'(s8c), 64'(es[2]));
        chk("w8c_cout", 64'(c8c), 64'(ec[2]));
        chk("w8c_cnt", 64'(n8c), 64'(popc(ec[2])));
        chk("w8c_valid", 64'(v8c), 64'(v));
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                m_sum[k] = '0; m_cout[k] = '0; m_cnt[k] = 0;
            end
        end else begin
            m_valid = v;
            if (v) begin
                for (int k = 0; k < 3; k++) begin
                    m_sum[k] = es[k]; m_cout[k] = ec[k]; m_cnt[k] = popc(ec[k]);
                end
            end
        end
        #1;
        chk("w1r_sum", 64'(s1r), 64'(m_sum[0]));
        chk("w1r_cout", 64'(c1r), 64'(m_cout[0]));
        chk("w1r_cnt", 64'(n1r), 64'(m_cnt[0]));
        chk("w1r_valid", 64'(v1r), 64'(m_valid));
        chk("w4r_sum", 64'(s4r), 64'(m_sum[1]));
        chk("w4r_cout", 64'(c4r), 64'(m_cout[1]));
        chk("w4r_cnt", 64'(n4r), 64'(m_cnt[1]));
        chk("w4r_valid", 64'(v4r), 64'(m_valid));
        chk("w8r_sum", 64'(s8r), 64'(m_sum[2]));
        chk("w8r_cout", 64'(c8r), 64'(m_cout[2]));
        chk("w8r_cnt", 64'(n8r), 64'(m_cnt[2]));
        chk("w8r_valid", 64'(v8r), 64'(m_valid));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] idx;

        // reset with a valid sample present: it must be discarded
        cycle(1'b1, 1'b1, 8'hFF, 8'hFF);
        chk("rst_w8r_valid", 64'(v8r), 64'h0);
        chk("rst_w8r_sum", 64'(s8r), 64'h0);
        cycle(1'b0, 1'b1, 8'h00, 8'h00);

        // single-lane truth table, streamed back to back
        cycle(1'b1, 1'b0, 8'h00, 8'h00);
        cycle(1'b1, 1'b0, 8'h00, 8'h01);
        chk("tt01_w1r", 64'({c1r, s1r}), 64'h1);
        cycle(1'b1, 1'b0, 8'h01, 8'h00);
        cycle(1'b1, 1'b0, 8'h01, 8'h01);
        chk("tt11_w1c", 64'({c1c, s1c, n1c}), 64'h5);
        chk("tt11_w1r", 64'({c1r, s1r, v1r}), 64'h5);

        // 8-lane combinational patterns
        cycle(1'b1, 1'b0, 8'hF0, 8'hCC);
        chk("f0cc_sum", 64'(s8c), 64'h3C);
        chk("f0cc_cout", 64'(c8c), 64'hC0);
        chk("f0cc_cnt", 64'(n8c), 64'd2);
        cycle(1'b1, 1'b0, 8'hFF, 8'hFF);
        chk("ffff_cnt", 64'(n8c), 64'd8);
        chk("ffff_w8r_cnt", 64'(n8r), 64'd8);

        // latency and hold
        cycle(1'b1, 1'b0, 8'hAA, 8'h55);
        chk("lat_sum", 64'(s8r), 64'hFF);
        chk("lat_cout", 64'(c8r), 64'h00);
        chk("lat_valid", 64'(v8r), 64'h1);
        cycle(1'b0, 1'b0, 8'h3C, 8'h3C);
        chk("hold_sum", 64'(s8r), 64'hFF);
        chk("hold_valid", 64'(v8r), 64'h0);
        chk("invalid_comb_follows", 64'(c8c), 64'h3C);

        // reset mid-stream flushes the stage
        cycle(1'b1, 1'b0, 8'h0F, 8'h0F);
        cycle(1'b1, 1'b1, 8'hFF, 8'hFF);
        chk("flush_valid", 64'(v8r), 64'h0);
        chk("flush_cout", 64'(c8r), 64'h0);
        chk("flush_cnt", 64'(n8r), 64'h0);
        cycle(1'b1, 1'b0, 8'h0F, 8'h01);
        chk("post_rst_sum", 64'(s8r), 64'h0E);
        chk("post_rst_cnt", 64'(n8r), 64'd1);
        chk("post_rst_valid", 64'(v8r), 64'h1);

        // every 4-bit a/b pair, upper lanes randomized
        for (int i = 0; i < 256; i++) begin
            idx = 8'(i);
            cycle(1'b1, 1'b0, {4'($urandom), idx[3:0]}, {4'($urandom), idx[7:4]});
        end

        // random traffic with occasional resets and idle cycles
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                  8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Bank of WIDTH independent 1-bit half adders: sum = a XOR b, cout = a AND b per lane.
- Optional output register stage with a valid qualifier, plus a per-sample carry population count.
- Leaf arithmetic primitive, used standalone and as the building block for full adders and ripple/compressor trees elsewhere in the datapath.
- Default configuration (WIDTH=1, REGISTERED=0) is the classic combinational half adder.

Parameters:
- WIDTH, 1, number of independent half-adder lanes; legal range 1..64.
- REGISTERED, 0, 0 = combinational outputs (zero latency); 1 = all outputs registered (one-cycle latency).
- CNT_W, $clog2(WIDTH+1), width of the carry_count output (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in_valid  input  1  qualifies a/b for the current cycle.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- sum  output  WIDTH  per-lane a XOR b.
- cout  output  WIDTH  per-lane a AND b.
- out_valid  output  1  qualifies sum/cout/carry_count.
- carry_count  output  CNT_W  number of set bits in cout.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Per lane i: sum[i] = a[i] ^ b[i] and cout[i] = a[i] & b[i]. There is no carry chain between lanes.
- Truth table per lane (a,b -> sum,cout):
  - 0,0 -> 0,0
  - 0,1 -> 1,0
  - 1,0 -> 1,0
  - 1,1 -> 0,1
- carry_count is the popcount of cout and ranges 0..WIDTH. It is zero-extended to CNT_W bits and never wraps.
- REGISTERED = 0:
  - sum, cout and carry_count are purely combinational from a and b, with no latency.
  - out_valid = in_valid combinationally.
  - clk and rst have no effect on the outputs.
  - Outputs follow a and b regardless of in_valid.
- REGISTERED = 1:
  - On each rising edge with rst = 0, out_valid <= in_valid.
  - When in_valid = 1, sum, cout and carry_count load the results for the current a and b. Latency is exactly 1 cycle.
  - When in_valid = 0, sum, cout and carry_count hold their previous values; only out_valid drops.
  - Back-to-back valid inputs give back-to-back valid outputs (throughput 1 per cycle). There is no backpressure.
- Reset (REGISTERED = 1):
  - While rst = 1 at a rising edge: sum = 0, cout = 0, carry_count = 0, out_valid = 0.
  - rst has priority over in_valid; a sample presented in the same cycle as rst is discarded.
  - Reset mid-stream flushes the output stage. The first valid output after reset deassertion comes 1 cycle after the first sampled in_valid.
- X/undefined inputs are not handled specially; no internal state beyond the single output stage.

Decomposition:
- Shared package: no typedefs are needed. Put the CNT_W helper (a clog2-based function) in the common arithmetic package for reuse by adders and compressors.
- Natural sub-module: half_adder_bit, the 1-bit combinational a/b -> sum/cout cell, instantiated WIDTH times via a generate loop.
- Keep the popcount and the register stage in the top level.

Test Plan:
- WIDTH=1, REGISTERED=0: apply the a,b sequence 00, 01, 10, 11, holding each for 10 time units -> sum,cout = 00, 10, 10, 01; carry_count = 0, 0, 0, 1.
- WIDTH=8, REGISTERED=0: a=8'hF0, b=8'hCC -> sum=8'h3C, cout=8'hC0, carry_count=2. Then a=b=8'hFF -> sum=8'h00, cout=8'hFF, carry_count=8.
- WIDTH=8, REGISTERED=1, latency:
  - in_valid=1 with a=8'hAA, b=8'h55 at cycle N -> at cycle N+1 out_valid=1, sum=8'hFF, cout=8'h00, carry_count=0.
  - Drive in_valid=0 at cycle N+1 -> at cycle N+2 out_valid=0 and outputs hold 8'hFF/8'h00.
- REGISTERED=1, streaming: 4 consecutive valid samples (00, 01, 10, 11 on WIDTH=1) -> 4 consecutive out_valid cycles with sum,cout = 00, 10, 10, 01, each delayed by exactly one cycle.
- REGISTERED=1, reset mid-stream: assert rst for 1 cycle while in_valid=1 and a=b=1 -> the next cycle shows out_valid=0, sum=0, cout=0, carry_count=0, and that sample never appears. Deassert rst -> the next valid sample emerges 1 cycle later.
- Exhaustive: WIDTH=4, all 256 a/b combinations in both REGISTERED modes, compared against a reference model (XOR, AND, popcount) -> zero mismatches.
